// File: rtl/axis_skid_buffer_if.sv
//------------------------------------------------------------------------------
// axis_skid_buffer_if
// AXI-Stream bundle used on both sides of axis_skid_buffer.
//   tdata  [DATA_WIDTH-1:0]  payload
//   tkeep  [KEEP_WIDTH-1:0]  byte enables (KEEP_WIDTH = DATA_WIDTH/8)
//   tlast                    end of packet
//   tuser  [USER_WIDTH-1:0]  sideband
//   tvalid                   source has a beat
//   tready                   sink can take a beat
// master: drives the beat and samples tready. slave: the reverse.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
interface axis_skid_buffer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int USER_WIDTH = 1
);
   localparam int KEEP_WIDTH = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] tdata;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic                  tlast;
   logic [USER_WIDTH-1:0] tuser;
   logic                  tvalid;
   logic                  tready;

   modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
   modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/axis_skid_buffer.sv
//------------------------------------------------------------------------------
// axis_skid_buffer
// Fully registered AXI-Stream slice with a two-entry (main + skid) buffer.
// Every output is a flop, so both the forward bundle and tready are cut,
// while still sustaining one beat per cycle.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   s_axis     upstream side (slave modport), tready from a flop
//   m_axis     downstream side (master modport), bundle/tvalid from flops
//   occupancy  beats held (0..2), from a flop
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module axis_skid_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int USER_WIDTH = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   axis_skid_buffer_if.slave    s_axis,
   axis_skid_buffer_if.master   m_axis,
   output logic [1:0]           occupancy
);
   localparam int KEEP_WIDTH = DATA_WIDTH / 8;
   localparam int BEAT_W     = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;

   // State codes double as the occupancy count.
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_BUSY  = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   logic [1:0]        r_state;
   logic [BEAT_W-1:0] r_main;
   logic [BEAT_W-1:0] r_skid;
   logic              r_valid;
   logic              r_ready;

   logic [BEAT_W-1:0] w_s_beat;
   logic              w_s_fire;
   logic              w_m_fire;

   assign w_s_beat = {s_axis.tdata, s_axis.tkeep, s_axis.tlast, s_axis.tuser};
   assign w_s_fire = s_axis.tvalid & r_ready;
   assign w_m_fire = r_valid & m_axis.tready;

   assign {m_axis.tdata, m_axis.tkeep, m_axis.tlast, m_axis.tuser} = r_main;
   assign m_axis.tvalid = r_valid;
   assign s_axis.tready = r_ready;
   assign occupancy     = r_state;

   // r_ready resets low and is raised by the first edge out of reset (the
   // EMPTY branch always reloads it), so nothing is taken during reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
         r_main  <= '0;
         r_skid  <= '0;
         r_valid <= 1'b0;
         r_ready <= 1'b0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               r_ready <= 1'b1;
               if (w_s_fire) begin
                  r_main  <= w_s_beat;
                  r_valid <= 1'b1;
                  r_state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (w_s_fire && w_m_fire) begin
                  r_main <= w_s_beat;
               end else if (w_s_fire) begin
                  // Downstream stalled: park the new beat, stop upstream.
                  r_skid  <= w_s_beat;
                  r_ready <= 1'b0;
                  r_state <= ST_FULL;
               end else if (w_m_fire) begin
                  r_valid <= 1'b0;
                  r_state <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               // ready is low here, so only the skid-to-main move can happen.
               if (w_m_fire) begin
                  r_main  <= r_skid;
                  r_ready <= 1'b1;
                  r_state <= ST_BUSY;
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_ready <= 1'b1;
               r_state <= ST_EMPTY;
            end
         endcase
      end
   end
endmodule

// File: doc/axis_skid_buffer.md
Name: axis_skid_buffer

Overview:
- Fully registered AXI-Stream pipeline slice with a two-entry skid buffer.
- Breaks the forward path (tdata/tkeep/tlast/tuser/tvalid) and the backward path (tready) with flops.
- Inserted wherever the combinational tready chain through forward-only register stages limits timing.
- Sustains one beat per cycle with no bubbles and no loss.

Parameters:
DATA_WIDTH, 32, tdata width in bits; must be a multiple of 8
USER_WIDTH, 1, tuser width in bits; must be at least 1
KEEP_WIDTH, DATA_WIDTH/8, tkeep width; derived, not overridden

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  reset, asynchronous, active-low
s_axis_tdata  input  DATA_WIDTH  upstream data
s_axis_tkeep  input  KEEP_WIDTH  upstream byte enables
s_axis_tlast  input  1  upstream end-of-packet
s_axis_tuser  input  USER_WIDTH  upstream sideband
s_axis_tvalid  input  1  upstream valid
s_axis_tready  output  1  upstream ready; driven directly from a flop
m_axis_tdata  output  DATA_WIDTH  downstream data; flop output
m_axis_tkeep  output  KEEP_WIDTH  downstream byte enables; flop output
m_axis_tlast  output  1  downstream end-of-packet; flop output
m_axis_tuser  output  USER_WIDTH  downstream sideband; flop output
m_axis_tvalid  output  1  downstream valid; flop output
m_axis_tready  input  1  downstream ready
occupancy  output  2  beats held: 0, 1 or 2; flop output

Behaviour:
- Definitions:
  - s_fire = s_axis_tvalid & s_axis_tready
  - m_fire = m_axis_tvalid & m_axis_tready
  - The beat bundle is {tdata, tkeep, tlast, tuser}.
- Storage: main register (drives m_axis_*) and skid register (holds one overflow beat).
- Reset, asynchronous, while rst_n=0:
  - State is EMPTY.
  - m_axis_tvalid=0, s_axis_tready=0, occupancy=0.
  - All data, keep, last and user flops (main and skid) are 0.
- s_axis_tready rises on the first clk edge after rst_n deasserts. No beat is accepted while ready is 0.
- State EMPTY (occupancy=0, m_axis_tvalid=0, s_axis_tready=1):
  - s_fire: main <= s beat; go to BUSY.
- State BUSY (occupancy=1, m_axis_tvalid=1, s_axis_tready=1):
  - s_fire & m_fire: main <= s beat; stay in BUSY.
  - s_fire & !m_fire: skid <= s beat; s_axis_tready <= 0; go to FULL.
  - !s_fire & m_fire: m_axis_tvalid <= 0; go to EMPTY.
  - No fire: hold.
- State FULL (occupancy=2, m_axis_tvalid=1, s_axis_tready=0):
  - m_fire: main <= skid; s_axis_tready <= 1; go to BUSY.
  - Otherwise hold everything.
- Latency: a beat accepted at edge N appears on m_axis_* after edge N, unless the main register is still occupied.
- Throughput: 1 beat/cycle when m_axis_tready=1 continuously. tready never drops under continuous flow.
- AXI-Stream rules:
  - While m_axis_tvalid=1 and m_axis_tready=0, the m_axis_* bundle is stable.
  - m_axis_tvalid never depends combinationally on m_axis_tready.
  - No combinational path exists from any input to any output.
- Ordering: beats leave in acceptance order. The bundle is transferred bit-exact, with tlast/tkeep/tuser kept with their tdata.
- Boundaries:
  - Skid overflow is impossible because ready is deasserted in FULL. s_axis_tvalid with ready=0 is ignored and holds no state.
  - In FULL, s_axis_tvalid=1 and m_fire in the same cycle: only the skid-to-main move happens. The upstream beat is accepted on a later cycle, after ready has risen.
  - m_axis_tready toggling while empty has no effect.
  - Reset asserted mid-packet discards all held beats. No partial packet is emitted after reset.
- Assertions the bench checks:
  - occupancy = m_axis_tvalid + (state==FULL).
  - s_axis_tready = (occupancy != 2) except during the first cycle after reset.

Test Plan:
- Reset then idle: rst_n low 3 cycles, then high → tvalid=0, occupancy=0, all m_* data 0; s_axis_tready=0 during reset, 1 from the first edge after release.
- Single beat: send tdata=0xDEADBEEF, tkeep=0xF, tlast=1, tuser=1 with m_axis_tready=1 → output after one edge with identical bundle, occupancy 1 then 0.
- Back-pressure fill: m_axis_tready=0; send 0x11, 0x22, 0x33 back-to-back.
  - 0x11 is held on m_axis with tvalid=1; 0x22 goes to skid; occupancy=2.
  - s_axis_tready=0 from the edge after 0x22 is accepted; 0x33 is not accepted.
  - Release ready → output order 0x11, 0x22, 0x33.
- Full throughput: stream 0..255 with m_axis_tready=1 → 256 beats out in 256 consecutive cycles, s_axis_tready never 0, order preserved.
- Random stress: 10,000 beats, random tvalid and random m_axis_tready at 50% each.
  - Scoreboard: every beat out equals the beat in, in order.
  - Output bundle stable whenever tvalid & !tready.
  - occupancy assertion holds every cycle.
- Reset mid-operation: reach occupancy=2, assert rst_n asynchronously between edges → m_axis_tvalid=0 and s_axis_tready=0 immediately; after release no stale beat is emitted.
